// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM between N_REQ pixel-side requesters.
// Round-robin arbitration with a strict-priority override for requester 0 during active video.
module sprite_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic                      Clk_Pixel,
  input  logic                      Rst_N,
  input  logic                      Pri_Mode,
  input  logic [N_REQ-1:0]          Req,
  input  logic [N_REQ*ADDR_W-1:0]   Req_Addr,
  output logic [N_REQ-1:0]          Gnt,
  output logic [ADDR_W-1:0]         Rom_Addr,
  output logic                      Rom_En,
  input  logic [DATA_W-1:0]         Rom_Dout,
  output logic                      Rd_Valid,
  output logic [$clog2(N_REQ)-1:0]  Rd_Id,
  output logic [DATA_W-1:0]         Rd_Data,
  output logic                      Busy
);

  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   next_ptr;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   issue_id;
  logic [ID_W-1:0]   idx_c;
  logic [N_REQ-1:0]  gnt_c;
  logic [ADDR_W-1:0] win_addr;
  logic              rr_win;
  logic              found_c;
  logic              accept;
  logic              inflight;

  logic              vld_p [ROM_LAT];
  logic [ID_W-1:0]   id_p  [ROM_LAT];

  // Grant selection: priority override first, else scan from ptr with wrap.
  always_comb begin
    gnt_c   = '0;
    win_id  = '0;
    rr_win  = 1'b0;
    found_c = 1'b0;
    idx_c   = '0;
    if (Pri_Mode && Req[0]) begin
      gnt_c[0] = 1'b1;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        idx_c = ID_W'((int'(ptr) + k) % N_REQ);
        if (!found_c && Req[idx_c]) begin
          found_c      = 1'b1;
          gnt_c[idx_c] = 1'b1;
          win_id       = idx_c;
        end
      end
      rr_win = found_c;
    end
  end

  always_comb begin
    win_addr = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (gnt_c[j]) win_addr = Req_Addr[j*ADDR_W +: ADDR_W];
    end
  end

  assign accept   = |gnt_c;
  assign next_ptr = ID_W'((int'(win_id) + 1) % N_REQ);
  assign Gnt      = gnt_c;

  // ---- issue stage: address register feeding the ROM ----
  always_ff @(posedge Clk_Pixel or negedge Rst_N) begin
    if (!Rst_N) begin
      ptr      <= '0;
      Rom_Addr <= '0;
      Rom_En   <= 1'b0;
      issue_id <= '0;
    end else begin
      Rom_En <= accept;
      if (accept) begin
        Rom_Addr <= win_addr;
        issue_id <= win_id;
      end
      // Priority grants leave the pointer alone so round-robin order resumes intact.
      if (rr_win) ptr <= next_ptr;
    end
  end

  // ---- return pipeline: {valid, id} tracks the ROM read latency ----
  always_ff @(posedge Clk_Pixel or negedge Rst_N) begin
    if (!Rst_N) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        vld_p[i] <= 1'b0;
        id_p[i]  <= '0;
      end
    end else begin
      vld_p[0] <= Rom_En;
      id_p[0]  <= issue_id;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        id_p[i]  <= id_p[i-1];
      end
    end
  end

  // ---- output stage: tag aligned with ROM douta ----
  assign Rd_Valid = vld_p[ROM_LAT-1];
  assign Rd_Id    = id_p[ROM_LAT-1];
  assign Rd_Data  = Rom_Dout;

  always_comb begin
    inflight = Rom_En;
    for (int i = 0; i < ROM_LAT; i++) inflight = inflight | vld_p[i];
  end

  assign Busy = (|Req) || inflight;

endmodule
